// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time system-ID checker: reads the ID and timestamp words from the sysid slave
// over Avalon-MM, compares them to expected values and reports pass/fail/timeout.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1362429039,
  parameter int          START_DELAY        = 16,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WAIT_MAX   = '1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY - 1);

  localparam logic [2:0] S_DELAY = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [DW-1:0] delay_cnt;
  logic [WW-1:0] wait_cnt;

  // Bus strobes decode straight from state, so RD_ID -> RD_TS keeps read high
  // and an async reset drops read immediately.
  assign avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
  assign avm_address = (state == S_RD_TS);
  assign busy        = (state != S_DONE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_DELAY;
      delay_cnt   <= '0;
      wait_cnt    <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      case (state)
        S_DELAY: begin
          if (delay_cnt == DELAY_LAST) begin
            delay_cnt <= '0;
            state     <= S_RD_ID;
          end else begin
            delay_cnt <= delay_cnt + 1'b1;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (!avm_waitrequest) begin
            wait_cnt <= '0;
            if (state == S_RD_ID) begin
              captured_id <= avm_readdata;
              state       <= S_RD_TS;
            end else begin
              captured_ts <= avm_readdata;
              state       <= S_CHECK;
            end
          end else if (TIMEOUT_CYCLES > 0 && wait_cnt == WAIT_LIM) begin
            timeout <= 1'b1;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            state   <= S_DONE;
          end else if (wait_cnt != WAIT_MAX) begin
            // saturate so a disabled timeout never wraps the counter
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          id_ok <= (captured_id == EXPECTED_ID);
          ts_ok <= (captured_ts == EXPECTED_TIMESTAMP);
          state <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_RD_ID;
          end
        end
        default: state <= S_DELAY;
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Scoreboard bench: each run pushes its predicted outcome; a monitor pops and
// compares on every rising edge of done. A stall-programmable slave model drives the bus.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'd0;
  localparam logic [31:0] EXP_TS  = 32'd1362429039;
  localparam int          SD      = 16;
  localparam int          T       = 8;
  localparam int          STUCK   = 1000;

  logic        clock, reset_n, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .START_DELAY(SD), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .captured_id(captured_id), .captured_ts(captured_ts)
  );

  typedef struct {
    int          done_cyc;
    int          rd_cycles;
    bit          id_ok, ts_ok, to;
    logic [31:0] cid, cts;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0, n_tot = 0;
  int cyc = 0;
  int rd_cnt = 0;

  // slave configuration for the current run
  int          cfg_sid, cfg_sts;
  logic [31:0] cfg_did, cfg_dts;
  int          left;
  bit          fresh = 1;
  bit          prev_stall = 0;
  logic        prev_addr = 0;

  // reference state: what the captured registers should hold
  logic [31:0] m_cid = 0, m_cts = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Slave model: each new read stalls for the configured number of cycles.
  always @(negedge clock) begin
    if (reset_n && avm_read) begin
      rd_cnt++;
      if (fresh) begin
        left  = avm_address ? cfg_sts : cfg_sid;
        fresh = 0;
      end else if (prev_stall) begin
        chk("addr_stable", avm_address, prev_addr);
      end
      if (left > 0) begin
        avm_waitrequest = 1;
        avm_readdata    = $urandom;
        left--;
      end else begin
        avm_waitrequest = 0;
        avm_readdata    = avm_address ? cfg_dts : cfg_did;
        fresh           = 1;
      end
    end else begin
      avm_waitrequest = 0;
      avm_readdata    = $urandom;
      fresh           = 1;
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
  end

  // Monitor: compare against the scoreboard on each rising edge of done.
  logic done_q = 0;
  always @(negedge clock) begin
    if (reset_n && done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc,         e.done_cyc);
        chk("read_cycles", rd_cnt,     e.rd_cycles);
        chk("id_ok",      id_ok,       e.id_ok);
        chk("ts_ok",      ts_ok,       e.ts_ok);
        chk("timeout",    timeout,     e.to);
        chk("captured_id", captured_id, e.cid);
        chk("captured_ts", captured_ts, e.cts);
        chk("busy_in_done", busy, 1'b0);
        chk("read_in_done", avm_read, 1'b0);
      end
    end
    done_q = reset_n ? done : 1'b0;
  end

  task automatic chk_reset_vals();
    chk("rst_read", avm_read, 0);     chk("rst_addr", avm_address, 0);
    chk("rst_busy", busy, 1);         chk("rst_done", done, 0);
    chk("rst_id_ok", id_ok, 0);       chk("rst_ts_ok", ts_ok, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cid", captured_id, 0);   chk("rst_cts", captured_ts, 0);
  endtask

  task automatic do_run(input bit from_reset, input int sid, input int sts,
                        input logic [31:0] did, input logic [31:0] dts, input bit pulse_in_delay);
    exp_t e;
    int   f, k;
    cfg_sid = sid; cfg_sts = sts; cfg_did = did; cfg_dts = dts;
    if (from_reset) begin
      @(negedge clock); reset_n = 0; sb.delete(); m_cid = 0; m_cts = 0;
      @(negedge clock); reset_n = 1; rd_cnt = 0;
      f = cyc + SD + 1;                // first RD_ID edge
    end else begin
      @(negedge clock); start = 1; rd_cnt = 0;
      f = cyc + 2;
    end
    e.id_ok = 0; e.ts_ok = 0; e.to = 0;
    if (sid > T) begin
      e.to = 1; e.done_cyc = f + T; e.rd_cycles = T + 1;
    end else begin
      m_cid = did;
      if (sts > T) begin
        e.to = 1; e.done_cyc = f + sid + 1 + T; e.rd_cycles = sid + T + 2;
      end else begin
        m_cts = dts;
        e.id_ok = (did == EXP_ID); e.ts_ok = (dts == EXP_TS);
        e.done_cyc = f + sid + sts + 2; e.rd_cycles = sid + sts + 2;
      end
    end
    e.cid = m_cid; e.cts = m_cts;
    sb.push_back(e);
    if (!from_reset) begin
      @(negedge clock); start = 0;
      chk("restart_done_clr", done, 0);   chk("restart_busy", busy, 1);
      chk("restart_id_clr", id_ok, 0);    chk("restart_ts_clr", ts_ok, 0);
      chk("restart_to_clr", timeout, 0);
    end else if (pulse_in_delay) begin
      repeat (3) @(negedge clock);
      start = 1;
      @(negedge clock); start = 0;
    end
    k = 0;
    while (!done && k < 400) begin @(negedge clock); k++; end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int k;
    reset_n = 0; start = 0;
    avm_waitrequest = 0; avm_readdata = 0;
    cfg_sid = 0; cfg_sts = 0; cfg_did = EXP_ID; cfg_dts = EXP_TS;
    #1 chk_reset_vals();
    repeat (2) @(negedge clock);

    do_run(1, 0, 0, EXP_ID, EXP_TS, 1);         // zero-wait, start ignored in DELAY
    do_run(0, 0, 0, 32'h1, EXP_TS, 0);          // bad ID
    do_run(1, 5, 5, EXP_ID, EXP_TS, 0);         // 5-cycle stalls
    do_run(0, STUCK, 0, EXP_ID, EXP_TS, 0);     // ID read times out
    do_run(0, 0, STUCK, 32'h5, EXP_TS, 0);      // TS read times out
    do_run(0, T, T, EXP_ID, EXP_TS, 0);         // longest stall that still completes
    do_run(0, T + 1, 0, EXP_ID, EXP_TS, 0);     // one past the limit
    do_run(1, STUCK, 0, EXP_ID, EXP_TS, 0);     // timeout straight after reset: captured_id stays 0

    // async reset while stalled in RD_TS
    cfg_sid = 0; cfg_sts = STUCK;
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    k = 0;
    while (!(avm_read && avm_address) && k < 20) begin @(negedge clock); k++; end
    chk("reached_rd_ts", avm_read && avm_address, 1);
    #2 reset_n = 0;
    #1 chk_reset_vals();
    sb.delete();
    do_run(1, 0, 0, EXP_ID, EXP_TS, 0);         // full rerun after reset

    for (int i = 0; i < 24; i++) begin
      int r1, r2;
      r1 = $urandom_range(0, 11); r2 = $urandom_range(0, 11);
      do_run($urandom_range(0, 5) == 0,
             (r1 <= 9) ? r1 : STUCK, (r2 <= 9) ? r2 : STUCK,
             ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID,
             ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS, $urandom_range(0, 1));
    end

    repeat (2) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
